// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Turns the host byte stream from the UART receiver into instruction-memory
//   writes, core run/step/restart control, and 32-bit data words returned to a
//   core load that is stalled waiting on the host.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   data_req          core is stalled on a host load (sampled in IDLE only)
//   imem_we/addr/wdata  instruction-memory write port (addr/wdata hold)
//   cpu_step          one-cycle single-step pulse
//   cpu_run           free-run level
//   cpu_restart       one-cycle PC-to-zero pulse
//   data_out/data_valid  word for the waiting load, with one-cycle strobe
//   busy              a frame is partially received
//   err               one-cycle pulse on bad opcode or inter-byte timeout
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a first byte (opcode, or data byte 0 if data_req)
// INSTR | collecting 4 little-endian instruction bytes
// DATA  | collecting 4 little-endian data bytes (byte 0 already taken)
module uart_cmd_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              data_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_step,
  output logic              cpu_run,
  output logic              cpu_restart,
  output logic [31:0]       data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_INSTR   = 8'h00;
  localparam logic [7:0] OP_RESTART = 8'h01;
  localparam logic [7:0] OP_STEP    = 8'h02;
  localparam logic [7:0] OP_RUN     = 8'h03;
  localparam logic [7:0] OP_HALT    = 8'h04;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       asm_merge;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_step_q, cpu_step_d;
  logic              cpu_run_q, cpu_run_d;
  logic              cpu_restart_q, cpu_restart_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              err_q, err_d;

  logic last_byte;
  logic tmo_hit;

  // Counter reaching TIMEOUT_CYC on this cycle with no byte arriving.
  assign last_byte = rx_valid && (cnt_q == 2'd3);
  assign tmo_hit   = !rx_valid && (tmo_q == TMO_LAST);

  // Current byte merged into its little-endian lane of the assembly register.
  always_comb begin
    asm_merge = asm_q;
    asm_merge[8*cnt_q +: 8] = rx_data;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (data_req)                 state_d = S_DATA;
          else if (rx_data == OP_INSTR) state_d = S_INSTR;
        end
      end
      S_INSTR, S_DATA: begin
        if (last_byte || tmo_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    wr_ptr_d      = wr_ptr_q;
    tmo_d         = '0;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    cpu_step_d    = 1'b0;
    cpu_run_d     = cpu_run_q;
    cpu_restart_d = 1'b0;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (data_req) begin
            asm_d = {24'h0, rx_data};
            cnt_d = 2'd1;
          end else begin
            unique case (rx_data)
              OP_INSTR: begin
                asm_d = '0;
                cnt_d = 2'd0;
              end
              OP_RESTART: begin
                cpu_restart_d = 1'b1;
                wr_ptr_d      = '0;
                cpu_run_d     = 1'b0;
              end
              OP_STEP:  cpu_step_d = !cpu_run_q;
              OP_RUN:   cpu_run_d  = 1'b1;
              OP_HALT:  cpu_run_d  = 1'b0;
              default:  err_d      = 1'b1;
            endcase
          end
        end
      end
      S_INSTR, S_DATA: begin
        if (rx_valid) begin
          asm_d = asm_merge;
          cnt_d = cnt_q + 2'd1;
          if (last_byte) begin
            if (state_q == S_INSTR) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = wr_ptr_q;
              imem_wdata_d = asm_merge;
              wr_ptr_d     = wr_ptr_q + 1'b1;
            end else begin
              data_valid_d = 1'b1;
              data_out_d   = asm_merge;
            end
          end
        end else if (tmo_hit) begin
          err_d = 1'b1;
          cnt_d = 2'd0;
          asm_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      asm_q         <= '0;
      wr_ptr_q      <= '0;
      tmo_q         <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      cpu_step_q    <= 1'b0;
      cpu_run_q     <= 1'b0;
      cpu_restart_q <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      wr_ptr_q      <= wr_ptr_d;
      tmo_q         <= tmo_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      cpu_step_q    <= cpu_step_d;
      cpu_run_q     <= cpu_run_d;
      cpu_restart_q <= cpu_restart_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      err_q         <= err_d;
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_step    = cpu_step_q;
  assign cpu_run     = cpu_run_q;
  assign cpu_restart = cpu_restart_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;

  localparam int ADDR_W = 2;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              data_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_step;
  logic              cpu_run;
  logic              cpu_restart;
  logic [31:0]       data_out;
  logic              data_valid;
  logic              busy;
  logic              err;

  uart_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .data_req   (data_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_step   (cpu_step),
    .cpu_run    (cpu_run),
    .cpu_restart(cpu_restart),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int n_we, n_step, n_rst, n_err, n_dv, n_wide;
  logic [ADDR_W-1:0] we_addr[$];
  logic [31:0]       we_data[$];
  logic              after_we, after_dv;
  logic [4:0]        prev_p = '0;

  always @(negedge clk) begin
    if (imem_we) begin
      n_we++;
      we_addr.push_back(imem_addr);
      we_data.push_back(imem_wdata);
    end
    if (cpu_step)    n_step++;
    if (cpu_restart) n_rst++;
    if (err)         n_err++;
    if (data_valid)  n_dv++;
    if ((prev_p & {imem_we, cpu_step, cpu_restart, err, data_valid}) != 5'b0) n_wide++;
    prev_p = {imem_we, cpu_step, cpu_restart, err, data_valid};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr();
    n_we = 0; n_step = 0; n_rst = 0; n_err = 0; n_dv = 0;
    we_addr.delete();
    we_data.delete();
  endtask

  // Byte is sampled on the next posedge; after_* capture outputs one cycle later.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    after_we = imem_we;
    after_dv = data_valid;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({imem_we, cpu_step, cpu_run, cpu_restart, data_valid, busy, err} !== 7'b0 ||
        imem_addr !== 2'd0 || imem_wdata !== 32'h0 || data_out !== 32'h0) begin
      $display("FAIL reset_outputs: ctl=%b addr=%0d wdata=%h dout=%h, required all zero",
               {imem_we, cpu_step, cpu_run, cpu_restart, data_valid, busy, err},
               imem_addr, imem_wdata, data_out);
    end else passed++;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr();
  endtask

  task automatic test_instr_write();
    clr();
    send_byte(8'h00);
    send_byte(8'h13);
    checks++;
    if (busy !== 1'b1) $display("FAIL instr_busy: got %b required 1", busy); else passed++;
    send_byte(8'h01); send_byte(8'h50); send_byte(8'h00);
    checks++;
    if (after_we !== 1'b1) $display("FAIL instr_latency: we one cycle after last byte %b required 1", after_we);
    else passed++;
    checks++;
    if (we_addr.size() < 1 || we_addr[0] !== 2'd0 || we_data[0] !== 32'h00500113)
      $display("FAIL instr_first: n_we=%0d, required addr 0 wdata 00500113", n_we);
    else passed++;
    send_frame(32'h00C00193);
    checks++;
    if (we_addr.size() != 2 || we_addr[1] !== 2'd1 || we_data[1] !== 32'h00C00193)
      $display("FAIL instr_second: n_we=%0d, required 2 writes, second addr 1 wdata 00C00193", n_we);
    else passed++;
    checks++;
    if (n_err != 0 || busy !== 1'b0) $display("FAIL instr_clean: err=%0d busy=%b required 0/0", n_err, busy);
    else passed++;
  endtask

  task automatic test_ctrl();
    clr();
    send_byte(8'h02);
    checks++;
    if (n_step != 1 || n_we != 0) $display("FAIL step_halted: steps=%0d we=%0d required 1/0", n_step, n_we);
    else passed++;
    send_byte(8'h03);
    checks++;
    if (cpu_run !== 1'b1) $display("FAIL run_set: got %b required 1", cpu_run); else passed++;
    send_byte(8'h02);
    checks++;
    if (n_step != 1) $display("FAIL step_running: steps=%0d required 1", n_step); else passed++;
    send_byte(8'h04);
    checks++;
    if (cpu_run !== 1'b0) $display("FAIL run_clear: got %b required 0", cpu_run); else passed++;
  endtask

  task automatic test_data();
    clr();
    data_req = 1'b1;
    send_byte(8'h07);
    checks++;
    if (busy !== 1'b1) $display("FAIL data_busy: got %b required 1", busy); else passed++;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    data_req = 1'b0;
    checks++;
    if (after_dv !== 1'b1 || n_dv != 1 || n_we != 0)
      $display("FAIL data_strobe: dv_latency=%b n_dv=%0d n_we=%0d required 1/1/0", after_dv, n_dv, n_we);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 32'h00000007) $display("FAIL data_hold: got %h required 00000007", data_out);
    else passed++;
  endtask

  task automatic test_timeout();
    clr();
    send_byte(8'h00); send_byte(8'h13); send_byte(8'h01);
    repeat (TMO + 10) @(posedge clk);
    #1;
    checks++;
    if (n_err != 1 || busy !== 1'b0 || n_we != 0)
      $display("FAIL timeout_abort: err=%0d busy=%b we=%0d required 1/0/0", n_err, busy, n_we);
    else passed++;
    send_frame(32'h008000EF);
    checks++;
    if (we_addr.size() != 1 || we_addr[0] !== 2'd2 || we_data[0] !== 32'h008000EF)
      $display("FAIL timeout_resume: n_we=%0d, required one write addr 2 wdata 008000EF", n_we);
    else passed++;
  endtask

  task automatic test_wrap_restart();
    clr();
    send_frame(32'h11111111);
    send_frame(32'h22222222);
    checks++;
    if (we_addr.size() != 2 || we_addr[0] !== 2'd3 || we_addr[1] !== 2'd0)
      $display("FAIL wrap_addr: n_we=%0d, required addrs 3 then 0", n_we);
    else passed++;
    send_byte(8'h03);
    send_byte(8'h01);
    checks++;
    if (n_rst != 1 || cpu_run !== 1'b0)
      $display("FAIL restart: pulses=%0d run=%b required 1/0", n_rst, cpu_run);
    else passed++;
    send_frame(32'h33333333);
    checks++;
    if (we_addr.size() != 3 || we_addr[2] !== 2'd0 || we_data[2] !== 32'h33333333)
      $display("FAIL restart_ptr: n_we=%0d, required third write addr 0 wdata 33333333", n_we);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6];
    seq = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
    clr();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rx_data  = seq[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (we_addr.size() != 1 || we_addr[0] !== 2'd1 || we_data[0] !== 32'hDDCCBBAA)
      $display("FAIL b2b_write: n_we=%0d, required one write addr 1 wdata DDCCBBAA", n_we);
    else passed++;
    checks++;
    if (n_step != 1 || n_err != 0) $display("FAIL b2b_opcode: steps=%0d err=%0d required 1/0", n_step, n_err);
    else passed++;
  endtask

  task automatic test_bad_opcode();
    clr();
    send_byte(8'h7F);
    checks++;
    if (n_err != 1 || busy !== 1'b0 || n_we != 0)
      $display("FAIL bad_op: err=%0d busy=%b we=%0d required 1/0/0", n_err, busy, n_we);
    else passed++;
    send_byte(8'h02);
    checks++;
    if (n_step != 1) $display("FAIL bad_op_idle: steps=%0d required 1", n_step); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    checks++;
    if (busy !== 1'b1 || cpu_run !== 1'b1) $display("FAIL mid_pre: busy=%b run=%b required 1/1", busy, cpu_run);
    else passed++;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_we, cpu_step, cpu_run, cpu_restart, data_valid, busy, err} !== 7'b0 ||
        imem_addr !== 2'd0 || imem_wdata !== 32'h0 || data_out !== 32'h0)
      $display("FAIL mid_reset: ctl=%b addr=%0d wdata=%h dout=%h, required all zero",
               {imem_we, cpu_step, cpu_run, cpu_restart, data_valid, busy, err},
               imem_addr, imem_wdata, data_out);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    clr();
    send_byte(8'h02);
    checks++;
    if (n_step != 1 || n_we != 0) $display("FAIL mid_after: steps=%0d we=%0d required 1/0", n_step, n_we);
    else passed++;
    send_frame(32'h00000093);
    checks++;
    if (we_addr.size() != 1 || we_addr[0] !== 2'd0 || we_data[0] !== 32'h00000093)
      $display("FAIL mid_ptr: n_we=%0d, required one write addr 0 wdata 00000093", n_we);
    else passed++;
  endtask

  task automatic test_pulse_width();
    checks++;
    if (n_wide != 0) $display("FAIL pulse_width: wide pulses=%0d required 0", n_wide); else passed++;
  endtask

  initial begin
    n_wide = 0;
    after_we = 1'b0;
    after_dv = 1'b0;
    test_reset();
    test_instr_write();
    test_ctrl();
    test_data();
    test_timeout();
    test_wrap_restart();
    test_back_to_back();
    test_bad_opcode();
    test_reset_mid_frame();
    test_pulse_width();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command sequencer between the UART byte receiver and the riscv core.
- Parses the host byte stream into three kinds of action:
  - instruction-memory writes;
  - core control (step/run/halt/pointer reset);
  - 32-bit data words returned to a core load that is waiting on the host.
- Sole writer of the instruction memory's load port. Sole source of core run/step control.

Parameters:
- ADDR_W, 8, instruction-memory word-address width. Write pointer wraps modulo 2^ADDR_W.
- TIMEOUT_CYC, 20000, idle clk cycles allowed between bytes of one frame before the frame is aborted. Must be greater than one byte time.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- data_req  in  1  level; core is stalled on a load waiting for a host word
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  instruction word for the write
- cpu_step  out  1  one-cycle pulse; core executes one instruction
- cpu_run  out  1  level; core free-runs while 1
- cpu_restart  out  1  one-cycle pulse; core PC returns to 0
- data_out  out  32  word delivered to the waiting load
- data_valid  out  1  one-cycle pulse; data_out is valid in this cycle
- busy  out  1  1 while a frame is partially received
- err  out  1  one-cycle pulse on a bad opcode or a frame timeout

Behaviour:
- Reset (asynchronous): every output is 0, state=IDLE, wr_ptr=0, byte count=0, timeout counter=0.
- States:
  - IDLE: waiting for a first byte.
  - INSTR: collecting 4 instruction bytes.
  - DATA: collecting 4 data bytes.
- IDLE, rx_valid with data_req=1:
  - The byte is data byte 0 (no opcode).
  - Next state DATA, count=1.
  - data_req is sampled only here.
- IDLE, rx_valid with data_req=0: the byte is an opcode.
  - 0x00: next state INSTR, count=0.
  - 0x01: cpu_restart pulse, wr_ptr=0, cpu_run=0. Stay IDLE.
  - 0x02: cpu_step pulse, only if cpu_run=0; otherwise ignored. Stay IDLE.
  - 0x03: cpu_run=1.
  - 0x04: cpu_run=0.
  - Any other value: err pulse, no other effect.
- INSTR/DATA: byte k (0..3) goes into bits [8k+7:8k] of the assembly register (little-endian).
- On the 4th byte, the cycle after that rx_valid:
  - INSTR: imem_we=1, imem_addr=wr_ptr, imem_wdata=assembled word. wr_ptr then increments and wraps at 2^ADDR_W.
  - DATA: data_valid=1, data_out=assembled word. data_out holds its value until the next DATA frame.
  - State returns to IDLE in the same cycle the strobe is asserted.
- Back-to-back bytes: a byte arriving in the strobe cycle is processed under IDLE rules. No byte is ever dropped.
- Latency: the first byte of a frame is accepted in the cycle it arrives. A write or data strobe is issued exactly 1 cycle after the final byte.
- busy is 1 in INSTR and DATA only.
- Timeout:
  - The counter runs in INSTR and DATA and clears on every rx_valid.
  - When it reaches TIMEOUT_CYC: err pulse, assembled data discarded, no strobe, return to IDLE, wr_ptr unchanged.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Pulse width: cpu_step, cpu_restart, err, imem_we and data_valid never exceed one cycle.
- Reset asserted mid-frame: the frame is lost, all outputs are 0 immediately, and the next byte after release is parsed as a fresh IDLE byte.

Test Plan:
- Send 00 13 01 50 00 -> one cycle of imem_we with addr=0, wdata=0x00500113; then 00 93 01 C0 00 -> addr=1, wdata=0x00C00193. No err.
- Send 02 with cpu_run=0 -> exactly one cpu_step pulse, no imem_we. Send 03 then 02 -> cpu_run=1, no step pulse. Send 04 -> cpu_run=0.
- Hold data_req=1, send 07 00 00 00 -> data_valid for one cycle, data_out=0x00000007, no imem_we, wr_ptr unchanged.
- Send 00 13 01 and then nothing for TIMEOUT_CYC cycles -> one err pulse, busy falls, no imem_we. A following 00 EF 00 80 00 -> write at the unchanged wr_ptr with wdata=0x008000EF.
- With ADDR_W=2: four instruction frames write addr 0,1,2,3 and a fifth writes addr 0. Then send 01 -> cpu_restart pulse, and the next write is addr 0.
- Send 0x7F -> one err pulse, state stays IDLE. Assert reset after 2 bytes of an INSTR frame -> all outputs 0; after release, send 02 -> treated as an opcode (cpu_step pulse).
